// File: rtl/mmio_bus_bridge.sv
// MEM-stage data bus bridge: decodes CPU loads/stores onto NUM_SLAVES base/mask windows
// with a registered strobe/ready handshake, wait-state timeout and fault reporting.
module mmio_bus_bridge #(
   parameter int NUM_SLAVES = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
      {32'h4000_0020, 32'h4000_0018, 32'h4000_0010, 32'h0000_0000},
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
      {32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hC000_0000},
   parameter int TIMEOUT = 255,
   parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         MemRead,
   input  logic                         MemWrite,
   input  logic [ADDR_W-1:0]            Address,
   input  logic [DATA_W-1:0]            Write_data,
   output logic [DATA_W-1:0]            Read_data,
   output logic                         Stall,
   output logic [NUM_SLAVES-1:0]        s_sel,
   output logic                         s_rd,
   output logic                         s_wr,
   output logic [ADDR_W-1:0]            s_addr,
   output logic [DATA_W-1:0]            s_wdata,
   input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
   input  logic [NUM_SLAVES-1:0]        s_ready,
   output logic                         bus_err,
   output logic [ADDR_W-1:0]            fault_addr,
   output logic [1:0]                   fsm_state
);

   // Handshake: a strobe (s_rd/s_wr with one s_sel bit) is held from the request edge until
   // the edge where the selected slave's s_ready is sampled high or the wait budget runs out;
   // the slave may hold s_ready for any number of cycles, only the selected bit is observed.

   localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state;
   logic [SEL_W-1:0]  sel_idx;
   logic [CNT_W-1:0]  wait_cnt;
   logic              req;
   logic              hit;
   logic [SEL_W-1:0]  hit_idx;

   assign req       = MemRead | MemWrite;
   assign Stall     = (state == S_WAIT) || ((state == S_IDLE) && req);
   assign fsm_state = state;

   // Scan downwards so the lowest-index matching window is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((Address & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
            hit     = 1'b1;
            hit_idx = i[SEL_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         sel_idx    <= '0;
         wait_cnt   <= '0;
         s_sel      <= '0;
         s_rd       <= 1'b0;
         s_wr       <= 1'b0;
         s_addr     <= '0;
         s_wdata    <= '0;
         Read_data  <= '0;
         bus_err    <= 1'b0;
         fault_addr <= '0;
      end else begin
         bus_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  s_addr  <= Address;
                  s_wdata <= Write_data;
                  if (hit) begin
                     sel_idx  <= hit_idx;
                     s_sel    <= NUM_SLAVES'(1) << hit_idx;
                     s_wr     <= MemWrite;
                     s_rd     <= ~MemWrite;
                     wait_cnt <= '0;
                     state    <= S_WAIT;
                  end else begin
                     Read_data  <= MemWrite ? '0 : ERR_DATA;
                     bus_err    <= 1'b1;
                     fault_addr <= Address;
                     state      <= S_DONE;
                  end
               end
            end
            S_WAIT: begin
               if (s_ready[sel_idx]) begin
                  Read_data <= s_wr ? '0 : s_rdata[sel_idx*DATA_W +: DATA_W];
                  s_sel     <= '0;
                  s_rd      <= 1'b0;
                  s_wr      <= 1'b0;
                  wait_cnt  <= '0;
                  state     <= S_DONE;
               end else if (wait_cnt == CNT_LAST) begin
                  // This is the TIMEOUT-th WAIT cycle without ready: abort the transfer.
                  Read_data  <= s_wr ? '0 : ERR_DATA;
                  bus_err    <= 1'b1;
                  fault_addr <= s_addr;
                  s_sel      <= '0;
                  s_rd       <= 1'b0;
                  s_wr       <= 1'b0;
                  wait_cnt   <= '0;
                  state      <= S_DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Self-checking bench for mmio_bus_bridge: directed plan cases plus random transactions
// checked against a window-decode / latency reference model.
module tb_mmio_bus_bridge;

   localparam int          TIMEOUT  = 255;
   localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

   logic         clk = 1'b0;
   logic         reset;
   logic         MemRead, MemWrite;
   logic [31:0]  Address, Write_data, Read_data;
   logic         Stall;
   logic [3:0]   s_sel;
   logic         s_rd, s_wr;
   logic [31:0]  s_addr, s_wdata;
   logic [127:0] s_rdata;
   logic [3:0]   s_ready;
   logic         bus_err;
   logic [31:0]  fault_addr;
   logic [1:0]   fsm_state;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] model_fault;
   logic [31:0] exp_q[$];
   logic [31:0] win_base[4] = '{32'h0000_0000, 32'h4000_0010, 32'h4000_0018, 32'h4000_0020};
   logic [31:0] win_mask[4] = '{32'hC000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFF8};

   mmio_bus_bridge dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .Address(Address), .Write_data(Write_data), .Read_data(Read_data), .Stall(Stall),
      .s_sel(s_sel), .s_rd(s_rd), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_ready(s_ready), .bus_err(bus_err), .fault_addr(fault_addr),
      .fsm_state(fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference decode: first window (lowest index) whose masked address equals its base.
   function automatic int model_decode(input logic [31:0] a);
      for (int i = 0; i < 4; i++) begin
         if ((a & win_mask[i]) == win_base[i]) return i;
      end
      return -1;
   endfunction

   // Driver + checker for one CPU access. Called just after a falling edge.
   // w = number of extra wait cycles before the slave answers; w < 0 means it never answers.
   task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdv, input int w);
      int          idx, exp_strobes, stall_n, strobe_n;
      logic        err, is_wr, done;
      logic [3:0]  noise, exp_sel;
      logic [31:0] exp_rd;
      idx   = model_decode(addr);
      is_wr = wr;
      if (idx < 0) begin
         err = 1'b1; exp_strobes = 0;
      end else if (w < 0 || w + 1 > TIMEOUT) begin
         err = 1'b1; exp_strobes = TIMEOUT;
      end else begin
         err = 1'b0; exp_strobes = w + 1;
      end
      exp_rd = is_wr ? 32'h0 : (err ? ERR_DATA : rdv);
      exp_q.push_back(exp_rd);
      if (err) model_fault = addr;
      exp_sel = (idx >= 0) ? 4'(1 << idx) : 4'h0;

      MemRead = rd; MemWrite = wr; Address = addr; Write_data = wdata;
      s_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (idx >= 0) s_rdata[idx*32 +: 32] = rdv;

      stall_n = 0; strobe_n = 0; done = 1'b0;
      for (int c = 0; c < TIMEOUT + 8 && !done; c++) begin
         noise = 4'($urandom);
         if (idx >= 0) noise[idx] = 1'b0;
         #1;
         if (s_rd | s_wr) begin
            strobe_n++;
            check("s_sel", {28'h0, s_sel}, {28'h0, exp_sel});
            check("s_rd", {31'h0, s_rd}, {31'h0, ~is_wr});
            check("s_wr", {31'h0, s_wr}, {31'h0, is_wr});
            check("s_addr", s_addr, addr);
            check("s_wdata", s_wdata, wdata);
            if (idx >= 0 && w >= 0 && strobe_n == w + 1) noise[idx] = 1'b1;
         end
         s_ready = noise;
         #1;
         if (Stall) begin
            stall_n++;
         end else begin
            done = 1'b1;
            check("Read_data", Read_data, exp_q.pop_front());
            check("bus_err_done", {31'h0, bus_err}, {31'h0, err});
            check("fault_addr", fault_addr, model_fault);
         end
         @(negedge clk);
      end
      check("done_reached", {31'h0, done}, 32'h1);
      check("stall_cycles", stall_n, exp_strobes + 1);
      check("strobe_cycles", strobe_n, exp_strobes);
      // Request is still held through DONE; it must not start a second transfer.
      MemRead = 1'b0; MemWrite = 1'b0; s_ready = 4'h0;
      #1;
      check("idle_stall", {31'h0, Stall}, 32'h0);
      check("idle_bus_err", {31'h0, bus_err}, 32'h0);
      check("idle_strobe", {31'h0, s_rd | s_wr}, 32'h0);
   endtask

   initial begin
      reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; Write_data = '0;
      s_rdata = '0; s_ready = '0; model_fault = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_sel", {28'h0, s_sel}, 32'h0);
      check("rst_strobes", {30'h0, s_rd, s_wr}, 32'h0);
      check("rst_addr", s_addr, 32'h0);
      check("rst_wdata", s_wdata, 32'h0);
      check("rst_rdata", Read_data, 32'h0);
      check("rst_bus_err", {31'h0, bus_err}, 32'h0);
      check("rst_fault", fault_addr, 32'h0);
      check("rst_stall", {31'h0, Stall}, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // directed plan cases
      run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 0);
      run_txn(1'b0, 1'b1, 32'h4000_0010, 32'hA5, 32'h5555_AAAA, 3);
      run_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 0);
      run_txn(1'b1, 1'b0, 32'h4000_0020, 32'h0, 32'h0BAD_0BAD, -1);
      run_txn(1'b1, 1'b1, 32'h0000_0004, 32'h0000_C0DE, 32'h7777_7777, 1);
      run_txn(1'b0, 1'b1, 32'h4000_0044, 32'h1111_2222, 32'h0, 0);
      run_txn(1'b0, 1'b1, 32'h4000_0027, 32'h3333_4444, 32'h0, -1);

      // random accesses
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         int          op, w;
         a  = ($urandom_range(0, 1) == 1) ? $urandom : (32'h4000_0000 | $urandom_range(0, 63));
         op = $urandom_range(0, 2);
         w  = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 6);
         @(negedge clk);
         run_txn(op != 1, op != 0, a, $urandom, $urandom, w);
      end

      // reset in the middle of a WAIT
      @(negedge clk);
      MemRead = 1'b1; Address = 32'h4000_0020; s_ready = 4'h0;
      repeat (4) @(negedge clk);
      #1;
      check("pre_rst_sel", {28'h0, s_sel}, 32'h8);
      check("pre_rst_rd", {31'h0, s_rd}, 32'h1);
      reset = 1'b1; MemRead = 1'b0;
      #1;
      check("mid_rst_sel", {28'h0, s_sel}, 32'h0);
      check("mid_rst_strobes", {30'h0, s_rd, s_wr}, 32'h0);
      check("mid_rst_stall", {31'h0, Stall}, 32'h0);
      model_fault = '0;
      check("mid_rst_fault", fault_addr, model_fault);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_rst_stall", {31'h0, Stall}, 32'h0);
      @(negedge clk);
      run_txn(1'b1, 1'b0, 32'h4000_0012, 32'h0, 32'hFEED_F00D, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
